// File: rtl/logic_axi4_stream_mux_arbiter_if.sv
// logic_axi4_stream_mux_arbiter_if: request/accept/grant bundle between the stream mux datapath and its arbiter.
interface logic_axi4_stream_mux_arbiter_if #(
    parameter int INPUTS = 2
);
    localparam int SW = INPUTS > 1 ? $clog2(INPUTS) : 1;
    logic [INPUTS-1:0] request;
    logic              accept;
    logic              last;
    logic [INPUTS-1:0] grant;
    logic [SW-1:0]     select;
    logic              locked;
    logic              timeout;
    modport master (input request, accept, last, output grant, select, locked, timeout);
    modport slave (output request, accept, last, input grant, select, locked, timeout);
endinterface

// File: rtl/logic_axi4_stream_mux_arbiter.sv
// logic_axi4_stream_mux_arbiter: packet-aware round-robin grant for the shared AXI4-Stream Tx port.
// Define LOGIC_AXI4_STREAM_MUX_ARBITER_TIMEOUT_EN to force release after TIMEOUT stalled BUSY cycles.
module logic_axi4_stream_mux_arbiter #(
    parameter int INPUTS = 2,
    parameter int USE_TLAST = 1,
    parameter int TIMEOUT = 256
) (
    input logic aclk,
    input logic areset_n,
    logic_axi4_stream_mux_arbiter_if.master arb
);
    localparam int SW = INPUTS > 1 ? $clog2(INPUTS) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    logic [0:0]        state;
    logic [INPUTS-1:0] grant_q, next_grant;
    logic [SW-1:0]     sel_q, ptr, base, winner;
    logic              found, rel_norm, force_rel, rearb;
    assign rel_norm = state == BUSY && arb.accept && (arb.last || USE_TLAST == 0);
    assign rearb = state == IDLE || rel_norm || force_rel;
    // on release the search starts just past the outgoing owner, making it lowest priority
    assign base = state == IDLE ? ptr : (int'(sel_q) == INPUTS - 1) ? '0 : sel_q + 1'b1;
    always_comb begin
        winner = '0;
        found = 1'b0;
        for (int k = INPUTS - 1; k >= 0; k--)
            if (arb.request[(int'(base) + k) % INPUTS]) begin
                winner = SW'((int'(base) + k) % INPUTS);
                found = 1'b1;
            end
        next_grant = '0;
        next_grant[winner] = found;
    end
    always_ff @(posedge aclk)
        if (!areset_n) begin
            state <= IDLE;
            grant_q <= '0;
            sel_q <= '0;
            ptr <= '0;
        end else if (rearb) begin
            state <= found ? BUSY : IDLE;
            grant_q <= next_grant;
            sel_q <= winner;
            if (state == BUSY) ptr <= base;
        end
`ifdef LOGIC_AXI4_STREAM_MUX_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] stall;
    logic          timeout_q;
    assign force_rel = state == BUSY && !rel_norm && int'(stall) == TIMEOUT;
    always_ff @(posedge aclk)
        if (!areset_n) begin
            stall <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall <= (state == IDLE || arb.accept || force_rel) ? '0 : stall + 1'b1;
            timeout_q <= force_rel;
        end
    assign arb.timeout = timeout_q;
`else
    assign force_rel = 1'b0;
    assign arb.timeout = 1'b0;
`endif
    assign arb.grant = grant_q;
    assign arb.select = sel_q;
    assign arb.locked = state == BUSY;
endmodule

// File: tb/tb_logic_axi4_stream_mux_arbiter.sv
// tb_logic_axi4_stream_mux_arbiter: directed bench with a per-cycle round-robin model for a tlast and a per-beat arbiter.
module tb_logic_axi4_stream_mux_arbiter;
    localparam int N = 4;
    localparam int TO = 8;
    logic clk = 1'b0;
    logic areset_n = 1'b0;
    always #5 clk = ~clk;
    logic_axi4_stream_mux_arbiter_if #(.INPUTS(N)) ia ();
    logic_axi4_stream_mux_arbiter_if #(.INPUTS(N)) ib ();
    logic_axi4_stream_mux_arbiter #(.INPUTS(N), .USE_TLAST(1), .TIMEOUT(TO)) dut_a (
        .aclk(clk), .areset_n(areset_n), .arb(ia));
    logic_axi4_stream_mux_arbiter #(.INPUTS(N), .USE_TLAST(0), .TIMEOUT(TO)) dut_b (
        .aclk(clk), .areset_n(areset_n), .arb(ib));
    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    int m_own[2];
    int m_p[2];
    int m_stall[2];
    bit m_to[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // model: owner index (-1 idle), priority pointer and stall count per instance; instance 1 ignores last
    always @(posedge clk) begin : model
        logic [N-1:0] req;
        bit acc, lst, rel, frc;
        for (int d = 0; d < 2; d++) begin
            req = d == 1 ? ib.request : ia.request;
            acc = d == 1 ? ib.accept : ia.accept;
            lst = d == 1 ? ib.last : ia.last;
            if (!areset_n) begin
                m_own[d] = -1;
                m_p[d] = 0;
                m_stall[d] = 0;
                m_to[d] = 1'b0;
            end else begin
                rel = m_own[d] >= 0 && acc && (lst || d == 1);
                frc = 1'b0;
`ifdef LOGIC_AXI4_STREAM_MUX_ARBITER_TIMEOUT_EN
                frc = m_own[d] >= 0 && !rel && m_stall[d] == TO;
`endif
                m_to[d] = frc;
                if (m_own[d] < 0 || rel || frc) begin
                    if (m_own[d] >= 0) m_p[d] = (m_own[d] + 1) % N;
                    m_own[d] = -1;
                    m_stall[d] = 0;
                    for (int k = 0; k < N; k++)
                        if (m_own[d] < 0 && req[(m_p[d] + k) % N]) m_own[d] = (m_p[d] + k) % N;
                end else m_stall[d] = acc ? 0 : m_stall[d] + 1;
            end
        end
    end

    always @(negedge clk)
        if (chk_en) begin
            check("grant_a", 32'(ia.grant), m_own[0] < 0 ? 0 : 32'(1) << m_own[0]);
            check("select_a", 32'(ia.select), m_own[0] < 0 ? 0 : m_own[0]);
            check("locked_a", 32'(ia.locked), 32'(m_own[0] >= 0));
            check("timeout_a", 32'(ia.timeout), 32'(m_to[0]));
            check("grant_b", 32'(ib.grant), m_own[1] < 0 ? 0 : 32'(1) << m_own[1]);
            check("select_b", 32'(ib.select), m_own[1] < 0 ? 0 : m_own[1]);
            check("locked_b", 32'(ib.locked), 32'(m_own[1] >= 0));
            check("timeout_b", 32'(ib.timeout), 32'(m_to[1]));
        end

    initial begin
        logic [N-1:0] rot[4];
        rot = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        ia.request = '0; ia.accept = 1'b0; ia.last = 1'b0;
        ib.request = '0; ib.accept = 1'b0; ib.last = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        check("reset_grant", 32'(ia.grant), 0);
        check("reset_locked", 32'(ia.locked), 0);
        areset_n = 1'b1;
        // first grant from pointer 0, then a 3-beat packet hands over with no gap
        ia.request = 4'b0110;
        tick();
        check("t1_grant", 32'(ia.grant), 32'b0010);
        check("t1_select", 32'(ia.select), 1);
        ia.accept = 1'b1;
        tick();
        tick();
        check("t1_mid", 32'(ia.grant), 32'b0010);
        ia.last = 1'b1;
        tick();
        check("t1_next_grant", 32'(ia.grant), 32'b0100);
        check("t1_next_select", 32'(ia.select), 2);
        ia.request = '0;
        tick();
        check("t1_idle", 32'(ia.grant), 0);
        ia.accept = 1'b0; ia.last = 1'b0;
        // rotation with all four requesting and single-beat packets
        areset_n = 1'b0;
        tick();
        areset_n = 1'b1;
        ia.request = 4'b1111;
        tick();
        check("t2_first", 32'(ia.grant), 32'b0001);
        ia.accept = 1'b1; ia.last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_rotate", 32'(ia.grant), 32'(rot[i]));
        end
        ia.request = '0;
        tick();
        check("t2_idle", 32'(ia.grant), 0);
        ia.accept = 1'b0; ia.last = 1'b0;
        // granted requester drops tvalid mid-packet and keeps the grant
        ia.request = 4'b0010;
        tick();
        check("t3_grant", 32'(ia.grant), 32'b0010);
        ia.request = '0;
        repeat (5) begin
            tick();
            check("t3_hold", 32'(ia.grant), 32'b0010);
        end
        ia.accept = 1'b1;
        tick();
        check("t3_hold_beat", 32'(ia.grant), 32'b0010);
        ia.last = 1'b1;
        tick();
        check("t3_release", 32'(ia.grant), 0);
        ia.accept = 1'b0; ia.last = 1'b0;
        // per-beat arbiter alternates between inputs 0 and 3
        ib.request = 4'b1001;
        tick();
        check("t4_g0", 32'(ib.grant), 32'b0001);
        ib.accept = 1'b1;
        tick();
        check("t4_g3", 32'(ib.grant), 32'b1000);
        check("t4_sel3", 32'(ib.select), 3);
        ib.last = 1'b1;
        tick();
        check("t4_g0b", 32'(ib.grant), 32'b0001);
        ib.last = 1'b0;
        tick();
        check("t4_g3b", 32'(ib.grant), 32'b1000);
        ib.request = '0;
        tick();
        check("t4_idle", 32'(ib.grant), 0);
        ib.accept = 1'b0;
        // reset while input 2 holds the grant
        ia.request = 4'b0100;
        tick();
        check("t5_busy", 32'(ia.grant), 32'b0100);
        areset_n = 1'b0;
        tick();
        check("t5_rst_grant", 32'(ia.grant), 0);
        check("t5_rst_select", 32'(ia.select), 0);
        check("t5_rst_locked", 32'(ia.locked), 0);
        areset_n = 1'b1;
        ia.request = 4'b1010;
        tick();
        check("t5_after", 32'(ia.grant), 32'b0010);
        ia.request = '0; ia.accept = 1'b1; ia.last = 1'b1;
        tick();
        ia.accept = 1'b0; ia.last = 1'b0;
        // stalled owner: pointer is 2, so input 0 wins over input 1
        ia.request = 4'b0011;
        tick();
        check("t6_grant", 32'(ia.grant), 32'b0001);
`ifdef LOGIC_AXI4_STREAM_MUX_ARBITER_TIMEOUT_EN
        repeat (8) tick();
        check("t6_pre_expiry", 32'(ia.grant), 32'b0001);
        check("t6_pre_timeout", 32'(ia.timeout), 0);
        tick();
        check("t6_forced", 32'(ia.grant), 32'b0010);
        check("t6_pulse", 32'(ia.timeout), 1);
        tick();
        check("t6_pulse_end", 32'(ia.timeout), 0);
        repeat (7) tick();
        check("t6_stalled", 32'(ia.grant), 32'b0010);
        ia.accept = 1'b1; ia.last = 1'b1;
        tick();
        check("t6_norm_grant", 32'(ia.grant), 32'b0001);
        check("t6_no_pulse", 32'(ia.timeout), 0);
`else
        repeat (12) tick();
        check("t6_held", 32'(ia.grant), 32'b0001);
        check("t6_timeout_tied", 32'(ia.timeout), 0);
        ia.accept = 1'b1; ia.last = 1'b1;
`endif
        ia.request = '0;
        tick();
        check("t6_idle", 32'(ia.grant), 0);
        // accept while idle changes nothing
        tick();
        check("idle_accept", 32'(ia.locked), 0);
        ia.accept = 1'b0; ia.last = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
